// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared screen geometry, draw-command record and blitter FSM states.
package boxhead_pkg;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PARK_X      = 1023;
    localparam int PARK_Y      = 511;
    localparam int SPRITE_ID_W = 6;

    typedef struct packed {
        logic [9:0]             x;
        logic [9:0]             y;
        logic [SPRITE_ID_W-1:0] id;
        logic [5:0]             w;
        logic [5:0]             h;
        logic                   flip;
    } blit_cmd_t;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} blit_state_e;
endpackage

// File: rtl/blit_cmd_fifo.sv
// blit_cmd_fifo: synchronous FIFO of draw commands; flush empties it but keeps a same-cycle push.
import boxhead_pkg::*;

module blit_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic      sram_clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  blit_cmd_t din,
    output blit_cmd_t dout,
    output logic      empty,
    output logic      full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_cnt;
    blit_cmd_t     r_mem [DEPTH];

    assign dout  = r_mem[r_rd];
    assign empty = r_cnt == '0;
    assign full  = r_cnt == (AW+1)'(DEPTH);

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= AW'(push);
            r_cnt <= (AW+1)'(push);
        end else begin
            r_rd  <= r_rd + AW'(pop);
            r_wr  <= r_wr + AW'(push);
            r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge sram_clk)
        if (push) r_mem[flush ? '0 : r_wr] <= din;
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: scans queued sprites out of ROM and presents opaque on-screen pixels to the SRAM controller.
// Define BLITTER_MIRROR_EN to honour cmd_flip (horizontal mirror of the ROM column).
import boxhead_pkg::*;

module sprite_blitter #(
    parameter int          CMD_DEPTH       = 8,
    parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
    input  logic                    sram_clk,
    input  logic                    reset,
    input  logic                    frame_clk,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [9:0]              cmd_x,
    input  logic [9:0]              cmd_y,
    input  logic [SPRITE_ID_W-1:0]  cmd_id,
    input  logic [5:0]              cmd_w,
    input  logic [5:0]              cmd_h,
    input  logic                    cmd_flip,
    output logic [SPRITE_ID_W+9:0]  rom_addr,
    input  logic [15:0]             rom_data,
    input  logic                    slot_ack,
    output logic [9:0]              program_x,
    output logic [9:0]              program_y,
    output logic [15:0]             program_data,
    output logic                    busy,
    output logic                    frame_overrun
);
    blit_state_e            r_state, w_next;
    blit_cmd_t              r_cmd, w_head, w_cmd;
    logic                   r_frame_q, r_frame_start, r_overrun, r_pv, r_pend;
    logic [4:0]             r_row, r_col, w_rom_col;
    logic [10:0]            r_px, r_py;
    logic [SPRITE_ID_W+9:0] r_paddr, w_addr;
    logic                   w_push, w_pop, w_empty, w_full;
    logic                   w_last_col, w_last_row, w_opaque, w_stall, w_load, w_issue;

    assign w_cmd     = '{x: cmd_x, y: cmd_y, id: cmd_id, w: cmd_w, h: cmd_h, flip: cmd_flip};
    assign w_push    = cmd_valid & cmd_ready;
    assign cmd_ready = ~w_full | w_pop;

    blit_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .sram_clk (sram_clk),
        .reset    (reset),
        .flush    (r_frame_start),
        .push     (w_push),
        .pop      (w_pop),
        .din      (w_cmd),
        .dout     (w_head),
        .empty    (w_empty),
        .full     (w_full)
    );

`ifdef BLITTER_MIRROR_EN
    assign w_rom_col = r_cmd.flip ? 5'(r_cmd.w - 6'd1 - {1'b0, r_col}) : r_col;
`else
    logic w_unused_flip;
    assign w_unused_flip = r_cmd.flip;
    assign w_rom_col     = r_col;
`endif

    assign w_last_col = {1'b0, r_col} == r_cmd.w - 6'd1;
    assign w_last_row = {1'b0, r_row} == r_cmd.h - 6'd1;
    assign w_addr     = {r_cmd.id, r_row, w_rom_col};
    assign w_opaque   = r_pv && rom_data != TRANSPARENT_KEY && r_px < 11'(SCREEN_W) && r_py < 11'(SCREEN_H);
    assign w_stall    = w_opaque & r_pend & ~slot_ack;
    assign w_load     = w_opaque & ~w_stall;
    assign w_issue    = (r_state == SCAN) & ~w_stall;
    // While stalled, re-present the waiting pixel's address so rom_data stays on that pixel.
    assign rom_addr      = w_stall ? r_paddr : w_addr;
    assign busy          = ~w_empty | (r_state != IDLE) | r_pend;
    assign frame_overrun = r_overrun;

    always_ff @(posedge sram_clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:  w_next = w_empty ? IDLE : LOAD;
            LOAD: begin
                w_pop  = ~w_empty;
                w_next = (w_head.w == '0 || w_head.h == '0) ? IDLE : SCAN;
            end
            SCAN:  w_next = (w_issue && w_last_col && w_last_row) ? DRAIN : SCAN;
            DRAIN: w_next = w_stall ? DRAIN : IDLE;
        endcase
        if (r_frame_start) w_next = IDLE;
    end

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            r_frame_q     <= 1'b0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_cmd         <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_pv          <= 1'b0;
            r_px          <= '0;
            r_py          <= '0;
            r_paddr       <= '0;
            r_pend        <= 1'b0;
            program_x     <= 10'(PARK_X);
            program_y     <= 10'(PARK_Y);
            program_data  <= '0;
        end else begin
            r_frame_q     <= frame_clk;
            r_frame_start <= frame_clk & ~r_frame_q;
            r_overrun     <= r_frame_start & busy;
            if (w_pop) begin
                r_cmd <= w_head;
                r_row <= '0;
                r_col <= '0;
            end else if (w_issue && !(w_last_col && w_last_row)) begin
                r_col <= w_last_col ? 5'd0 : r_col + 5'd1;
                r_row <= w_last_col ? r_row + 5'd1 : r_row;
            end
            if (r_frame_start) begin
                r_pv <= 1'b0;
            end else if (!w_stall) begin
                r_pv    <= r_state == SCAN;
                r_px    <= {1'b0, r_cmd.x} + {6'd0, r_col};
                r_py    <= {1'b0, r_cmd.y} + {6'd0, r_row};
                r_paddr <= w_addr;
            end
            // A swap parks the output so a stale pixel never lands in the new hidden frame.
            if (r_frame_start) begin
                r_pend       <= 1'b0;
                program_x    <= 10'(PARK_X);
                program_y    <= 10'(PARK_Y);
                program_data <= '0;
            end else if (w_load) begin
                r_pend       <= 1'b1;
                program_x    <= r_px[9:0];
                program_y    <= r_py[9:0];
                program_data <= rom_data;
            end else if (slot_ack) begin
                r_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table of sprite commands checked against a pixel scoreboard, plus frame-swap, latency and FIFO-full sequences.
import boxhead_pkg::*;

module tb_sprite_blitter;
    localparam logic [15:0] KEY = 16'hF81F;
    localparam int DEPTH = 8;

    typedef struct {int x; int y; int id; int w; int h; int flip; int n;} vec_t;
    typedef struct packed {logic [9:0] x; logic [9:0] y; logic [15:0] d;} pix_t;

    logic sram_clk = 0, reset = 1, frame_clk = 0, cmd_valid = 0, cmd_flip = 0, slot_ack = 0;
    logic [9:0] cmd_x = 0, cmd_y = 0;
    logic [SPRITE_ID_W-1:0] cmd_id = 0;
    logic [5:0] cmd_w = 0, cmd_h = 0;
    logic [SPRITE_ID_W+9:0] rom_addr;
    logic [15:0] rom_data = 0, program_data;
    logic [9:0] program_x, program_y;
    logic cmd_ready, busy, frame_overrun;
    logic ack_en = 0, ack_ph = 0;
    int n_vec = 0, n_err = 0, seen = 0, ov_cnt = 0;
    pix_t q[$];
    pix_t prev = '{10'd1023, 10'd511, 16'd0};

    sprite_blitter #(.CMD_DEPTH(DEPTH), .TRANSPARENT_KEY(KEY)) dut (
        .sram_clk(sram_clk), .reset(reset), .frame_clk(frame_clk),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_id(cmd_id), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_flip(cmd_flip),
        .rom_addr(rom_addr), .rom_data(rom_data), .slot_ack(slot_ack),
        .program_x(program_x), .program_y(program_y), .program_data(program_data),
        .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 sram_clk = ~sram_clk;

    // Sprite ROM: word = its own address, except sprite 5 column 1 which is transparent.
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return (a[15:10] == 6'd5 && a[4:0] == 5'd1) ? KEY : a;
    endfunction

    always @(posedge sram_clk) rom_data <= rom_fn(rom_addr);

    initial forever begin
        @(posedge sram_clk);
        #1;
        ack_ph = ~ack_ph;
        slot_ack = ack_en & ack_ph;
    end

    always @(negedge sram_clk) if (!reset && frame_overrun) ov_cnt++;

    // Every new non-park value on program_* is one presented pixel.
    always @(negedge sram_clk) begin
        pix_t cur, e;
        cur = '{program_x, program_y, program_data};
        if (!reset && cur != prev) begin
            prev = cur;
            if (!(cur.x == 10'd1023 && cur.y == 10'd511)) begin
                seen++;
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel: got (%0d,%0d,%h) required none", cur.x, cur.y, cur.d);
                end else begin
                    e = q.pop_front();
                    if (cur != e) begin
                        n_err++;
                        $display("FAIL pixel: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                                 cur.x, cur.y, cur.d, e.x, e.y, e.d);
                    end
                end
            end
        end
    end

    function automatic int expect_sprite(int x, int y, int id, int w, int h, int flip);
        int n, rc;
        logic [15:0] d;
        n = 0;
        if (w == 0 || h == 0) return 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                rc = c;
`ifdef BLITTER_MIRROR_EN
                if (flip != 0) rc = w - 1 - c;
`endif
                d = rom_fn({6'(id), 5'(r), 5'(rc)});
                if (d != KEY && x + c < 640 && y + r < 480) begin
                    q.push_back('{10'(x + c), 10'(y + r), d});
                    n++;
                end
            end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input int x, input int y, input int id, input int w, input int h, input int flip);
        int t;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(posedge sram_clk);
            #1;
            t++;
        end
        if (!cmd_ready) chk("push_timeout", 0, 1);
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_id = 6'(id);
        cmd_w = 6'(w); cmd_h = 6'(h); cmd_flip = flip[0];
        cmd_valid = 1;
        @(posedge sram_clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((busy || q.size() != 0) && t < 5000) begin
            @(posedge sram_clk);
            #1;
            t++;
        end
        if (t >= 5000) chk({nm, "_timeout"}, 0, 1);
        repeat (6) @(posedge sram_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[10];
        int acc, lat, ov0;
        logic rdy;
        v[0] = '{100, 50, 3, 2, 2, 0, 4};
        v[1] = '{10, 20, 5, 3, 1, 0, 2};
        v[2] = '{630, 470, 4, 16, 16, 0, 100};
        v[3] = '{0, 0, 6, 4, 1, 1, 4};
        v[4] = '{639, 479, 8, 1, 1, 0, 1};
        v[5] = '{640, 10, 8, 1, 1, 0, 0};
        v[6] = '{50, 60, 9, 0, 3, 0, 0};
        v[7] = '{5, 5, 2, 3, 0, 0, 0};
        v[8] = '{300, 200, 11, 32, 2, 0, 64};
        v[9] = '{1000, 10, 12, 4, 4, 0, 0};

        repeat (3) @(posedge sram_clk);
        #1;
        reset = 0;
        chk("rst_x", int'(program_x), 1023);
        chk("rst_y", int'(program_y), 511);
        chk("rst_data", int'(program_data), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(frame_overrun), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);

        ack_en = 1;
        for (int i = 0; i < 10; i++) begin
            seen = 0;
            void'(expect_sprite(v[i].x, v[i].y, v[i].id, v[i].w, v[i].h, v[i].flip));
            push_cmd(v[i].x, v[i].y, v[i].id, v[i].w, v[i].h, v[i].flip);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_pixels", i), seen, v[i].n);
            chk($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // Pop in LOAD to first pixel in the output register is 3 cycles, 5 edges after the push is driven.
        seen = 0;
        void'(expect_sprite(400, 400, 13, 1, 1, 0));
        cmd_x = 400; cmd_y = 400; cmd_id = 13; cmd_w = 1; cmd_h = 1; cmd_flip = 0;
        cmd_valid = 1;
        @(posedge sram_clk);
        #1;
        cmd_valid = 0;
        lat = 1;
        while (program_x != 10'd400 && lat < 20) begin
            @(posedge sram_clk);
            #1;
            lat++;
        end
        chk("latency", lat, 5);
        wait_idle("latency");

        // Frame swap in the middle of a 32x32 sprite.
        seen = 0;
        ov0 = ov_cnt;
        void'(expect_sprite(200, 100, 7, 32, 32, 0));
        push_cmd(200, 100, 7, 32, 32, 0);
        lat = 0;
        while (seen < 50 && lat < 2000) begin
            @(posedge sram_clk);
            #1;
            lat++;
        end
        chk("ovr_reach50", int'(seen >= 50), 1);
        frame_clk = 1;
        repeat (2) @(posedge sram_clk);
        #1;
        q.delete();
        chk("ovr_park_x", int'(program_x), 1023);
        chk("ovr_park_y", int'(program_y), 511);
        chk("ovr_park_data", int'(program_data), 0);
        chk("ovr_busy", int'(busy), 0);
        repeat (4) @(posedge sram_clk);
        #1;
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_stays_park", int'(program_x), 1023);
        frame_clk = 0;
        seen = 0;
        void'(expect_sprite(20, 30, 3, 2, 2, 0));
        push_cmd(20, 30, 3, 2, 2, 0);
        wait_idle("after_swap");
        chk("after_swap_pixels", seen, 4);

        // Idle swap: a push in the frame_start cycle survives, no overrun.
        seen = 0;
        ov0 = ov_cnt;
        frame_clk = 1;
        @(posedge sram_clk);
        #1;
        void'(expect_sprite(70, 80, 9, 2, 1, 0));
        push_cmd(70, 80, 9, 2, 1, 0);
        wait_idle("swap_push");
        chk("swap_push_pixels", seen, 2);
        chk("swap_idle_overrun", ov_cnt - ov0, 0);
        frame_clk = 0;

        // No acks: the FIFO fills behind one stalled sprite.
        ack_en = 0;
        repeat (3) @(posedge sram_clk);
        #1;
        seen = 0;
        acc = 0;
        cmd_valid = 1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            cmd_x = 10'(100 + 10 * acc); cmd_y = 300; cmd_id = 20; cmd_w = 2; cmd_h = 1; cmd_flip = 0;
            rdy = cmd_ready;
            @(posedge sram_clk);
            #1;
            if (rdy) begin
                void'(expect_sprite(100 + 10 * acc, 300, 20, 2, 1, 0));
                acc++;
            end
        end
        cmd_valid = 0;
        chk("full_accepted", acc, DEPTH + 1);
        chk("full_ready", int'(cmd_ready), 0);
        chk("full_busy", int'(busy), 1);
        chk("full_stalled_pixels", seen, 1);
        ack_en = 1;
        wait_idle("full_drain");
        chk("full_drain_pixels", seen, 2 * (DEPTH + 1));
        chk("full_drain_ready", int'(cmd_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
